aes_avalon_regs: RTL and testbench

//  Upstream neighbour of the AES decryption core: an Avalon-MM slave register file.
//  - Software writes the 128-bit key and ciphertext, then starts a run.
//  - The block drives the core's AES_START / AES_KEY / AES_MSG_ENC.
//  - On AES_DONE it captures AES_MSG_DEC and exposes it with a DONE flag for polling.
//  - The core is instantiated beside this block, not inside it.

---
 rtl/aes_regs_pkg.sv | 19 +
 rtl/avl_byte_reg.sv | 31 +++
 rtl/aes_avalon_regs.sv | 161 ++++++++++++++++
 tb/tb_aes_avalon_regs.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_regs_pkg.sv
// Shared constants and types for the AES Avalon-MM register block.
package aes_regs_pkg;

  // Word addresses of the register groups.
  localparam logic [3:0] ADDR_KEY0   = 4'd0;
  localparam logic [3:0] ADDR_ENC0   = 4'd4;
  localparam logic [3:0] ADDR_DEC0   = 4'd8;
  localparam logic [3:0] ADDR_SPARE0 = 4'd12;
  localparam logic [3:0] ADDR_START  = 4'd14;
  localparam logic [3:0] ADDR_DONE   = 4'd15;

  // Control sequencer: RUN waits for the core, HOLD keeps START high until software clears it.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/avl_byte_reg.sv
// One 32-bit software-visible register with per-byte write enables.
module avl_byte_reg #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  we_i,
  input  logic [DATA_W/8-1:0]   be_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     q_o
);

  logic [DATA_W-1:0] data_q;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W/8; gi++) begin : g_lane
      // Each byte lane updates only when its byte enable is set.
      always_ff @(posedge clk) begin
        if (srst) begin
          data_q[gi*8 +: 8] <= 8'h00;
        end else if (we_i && be_i[gi]) begin
          data_q[gi*8 +: 8] <= wdata_i[gi*8 +: 8];
        end
      end
    end
  endgenerate

  assign q_o = data_q;

endmodule

// File: rtl/aes_avalon_regs.sv
// Avalon-MM register file feeding the AES decryption core: key/ciphertext in,
// start/done handshake, captured plaintext out.
module aes_avalon_regs
  import aes_regs_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 32
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        AVL_CS,
  input  logic                        AVL_READ,
  input  logic                        AVL_WRITE,
  input  logic [$clog2(NUM_REGS)-1:0] AVL_ADDR,
  input  logic [DATA_W/8-1:0]         AVL_BYTE_EN,
  input  logic [DATA_W-1:0]           AVL_WRITEDATA,
  output logic [DATA_W-1:0]           AVL_READDATA,
  output logic                        AES_START,
  input  logic                        AES_DONE,
  output logic [127:0]                AES_KEY,
  output logic [127:0]                AES_MSG_ENC,
  input  logic [127:0]                AES_MSG_DEC,
  output logic [31:0]                 EXPORT_DATA
);

  localparam int ADDR_W = $clog2(NUM_REGS);

  ctrl_state_t       state_q, state_d;
  logic              done_q, done_d;
  logic              start_q;
  logic              capture;
  logic [DATA_W-1:0] dec_q [4];
  logic [DATA_W-1:0] word  [NUM_REGS];

  logic wr_en;
  logic start_wr;

  assign wr_en    = AVL_CS && AVL_WRITE;
  assign start_wr = wr_en && (AVL_ADDR == ADDR_W'(ADDR_START)) && AVL_BYTE_EN[0];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_word
      if (gi < int'(ADDR_DEC0)) begin : g_keymsg
        // Key and ciphertext are frozen while a run is in progress.
        logic we;
        assign we = wr_en && (AVL_ADDR == ADDR_W'(gi)) && (state_q == IDLE);
        avl_byte_reg #(.DATA_W(DATA_W)) u_reg (
          .clk     (CLK),
          .srst    (RESET),
          .we_i    (we),
          .be_i    (AVL_BYTE_EN),
          .wdata_i (AVL_WRITEDATA),
          .q_o     (word[gi])
        );
      end else if (gi < int'(ADDR_SPARE0)) begin : g_dec
        assign word[gi] = dec_q[gi - int'(ADDR_DEC0)];
      end else if (gi < int'(ADDR_START)) begin : g_spare
        logic we;
        assign we = wr_en && (AVL_ADDR == ADDR_W'(gi));
        avl_byte_reg #(.DATA_W(DATA_W)) u_reg (
          .clk     (CLK),
          .srst    (RESET),
          .we_i    (we),
          .be_i    (AVL_BYTE_EN),
          .wdata_i (AVL_WRITEDATA),
          .q_o     (word[gi])
        );
      end else if (gi == int'(ADDR_START)) begin : g_start
        assign word[gi] = DATA_W'(start_q);
      end else if (gi == int'(ADDR_DONE)) begin : g_done
        assign word[gi] = DATA_W'(done_q);
      end else begin : g_unused
        assign word[gi] = '0;
      end
    end

    for (gi = 0; gi < 4; gi++) begin : g_capture
      // Plaintext words latch only on the RUN->HOLD transition; reg8 holds the top word.
      always_ff @(posedge CLK) begin
        if (RESET) begin
          dec_q[gi] <= '0;
        end else if (capture) begin
          dec_q[gi] <= AES_MSG_DEC[(4-gi)*DATA_W-1 -: DATA_W];
        end
      end
    end
  endgenerate

  // START bit0 mirrors whatever software last wrote, independent of the sequencer.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      start_q <= 1'b0;
    end else if (start_wr) begin
      start_q <= AVL_WRITEDATA[0];
    end
  end

  // Sequencer state and DONE flag registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; an abort write takes priority over a concurrent AES_DONE.
  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_wr && AVL_WRITEDATA[0]) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (start_wr && !AVL_WRITEDATA[0]) begin
          state_d = IDLE;
        end else if (AES_DONE) begin
          state_d = HOLD;
          capture = 1'b1;
          done_d  = 1'b1;
        end
      end
      HOLD: begin
        if (start_wr && !AVL_WRITEDATA[0]) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Zero-wait-state read mux; unselected or unmapped addresses read as zero.
  always_comb begin
    AVL_READDATA = '0;
    if (AVL_CS && AVL_READ) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (AVL_ADDR == ADDR_W'(i)) begin
          AVL_READDATA = word[i];
        end
      end
    end
  end

  assign AES_START   = (state_q != IDLE);
  assign AES_KEY     = {word[int'(ADDR_KEY0)],   word[int'(ADDR_KEY0)+1],
                        word[int'(ADDR_KEY0)+2], word[int'(ADDR_KEY0)+3]};
  assign AES_MSG_ENC = {word[int'(ADDR_ENC0)],   word[int'(ADDR_ENC0)+1],
                        word[int'(ADDR_ENC0)+2], word[int'(ADDR_ENC0)+3]};
  assign EXPORT_DATA = {AES_KEY[127:112], AES_KEY[15:0]};

endmodule

// File: tb/tb_aes_avalon_regs.sv
// Directed bench for aes_avalon_regs with a behavioural AES core stand-in.
module tb_aes_avalon_regs;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cs = 1'b0, rd_s = 1'b0, wr_s = 1'b0;
  logic [3:0]   addr = '0;
  logic [3:0]   be = '0;
  logic [31:0]  wdata = '0;
  logic [31:0]  rdata;
  logic         aes_start;
  logic         aes_done;
  logic [127:0] aes_key, aes_enc;
  logic [127:0] aes_dec = 128'h00112233445566778899aabbccddeeff;
  logic [31:0]  export_data;

  logic         model_en = 1'b0;
  logic         model_done = 1'b0;
  logic         force_done = 1'b0;
  int           model_cnt = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign aes_done = model_done | force_done;

  aes_avalon_regs dut (
    .CLK           (clk),
    .RESET         (rst),
    .AVL_CS        (cs),
    .AVL_READ      (rd_s),
    .AVL_WRITE     (wr_s),
    .AVL_ADDR      (addr),
    .AVL_BYTE_EN   (be),
    .AVL_WRITEDATA (wdata),
    .AVL_READDATA  (rdata),
    .AES_START     (aes_start),
    .AES_DONE      (aes_done),
    .AES_KEY       (aes_key),
    .AES_MSG_ENC   (aes_enc),
    .AES_MSG_DEC   (aes_dec),
    .EXPORT_DATA   (export_data)
  );

  // Core stand-in: raises done 30 cycles after start and holds it until start falls.
  always @(posedge clk) begin
    if (rst || !aes_start) begin
      model_cnt  <= 0;
      model_done <= 1'b0;
    end else if (model_en) begin
      if (model_cnt == 29) model_done <= 1'b1;
      else                 model_cnt  <= model_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] b, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; wr_s = 1'b1; addr = a; be = b; wdata = d;
    @(posedge clk);
    #1;
    cs = 1'b0; wr_s = 1'b0;
    $display("write addr=%0d be=%b data=%h", a, b, d);
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; rd_s = 1'b1; addr = a;
    #1;
    d = rdata;
    cs = 1'b0; rd_s = 1'b0;
    $display("read  addr=%0d data=%h", a, d);
  endtask

  logic [31:0] d;
  logic [31:0] key_w [4] = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
  logic [31:0] enc_w [4] = '{32'h69c4e0d8, 32'h6a7b0430, 32'h d8cdb780, 32'h70b4c55a};
  logic [31:0] dec_w [4] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_start", aes_start, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    rst = 1'b0;
    rd(4'd15, d); chk("rst_done", d, 32'h0);
    rd(4'd0, d);  chk("rst_reg0", d, 32'h0);

    // Simultaneous read and write returns the pre-write value
    wr(4'd12, 4'hf, 32'h11111111);
    @(negedge clk);
    cs = 1'b1; rd_s = 1'b1; wr_s = 1'b1; addr = 4'd12; be = 4'hf; wdata = 32'h22222222;
    #1;
    chk("rw_prewrite", rdata, 32'h11111111);
    @(posedge clk); #1;
    cs = 1'b0; rd_s = 1'b0; wr_s = 1'b0;
    rd(4'd12, d); chk("rw_postwrite", d, 32'h22222222);

    // Byte-enable write
    wr(4'd0, 4'b0101, 32'hdeadbeef);
    rd(4'd0, d); chk("be_reg0", d, 32'h00ad00ef);
    chk("be_export", export_data, 32'h00ad0000);

    // Load FIPS-197 key and ciphertext
    for (int i = 0; i < 4; i++) wr(4'(i), 4'hf, key_w[i]);
    for (int i = 0; i < 4; i++) wr(4'(4 + i), 4'hf, enc_w[i]);
    chk("key_out", aes_key, 128'h000102030405060708090a0b0c0d0e0f);
    chk("enc_out", aes_enc, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk("export_key", export_data, 32'h00010e0f);

    // Start run: AES_START rises on the write edge
    model_en = 1'b1;
    wr(4'd14, 4'hf, 32'hffffffff);
    chk("start_rise", aes_start, 1'b1);
    rd(4'd14, d); chk("start_rd", d, 32'h1);
    rd(4'd15, d); chk("done_running", d, 32'h0);

    // Key/msg frozen during RUN
    wr(4'd4, 4'hf, 32'hffffffff);
    rd(4'd4, d); chk("run_reg4", d, 32'h69c4e0d8);
    chk("run_enc", aes_enc, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    // Poll DONE with a bounded wait
    d = '0;
    for (int i = 0; i < 100; i++) begin
      rd(4'd15, d);
      if (d == 32'h1) break;
    end
    chk("done_poll", d, 32'h1);
    for (int i = 0; i < 4; i++) begin
      rd(4'(8 + i), d);
      chk($sformatf("dec_reg%0d", 8 + i), d, dec_w[i]);
    end

    // Read-only registers ignore writes
    wr(4'd9, 4'hf, 32'h12345678);
    rd(4'd9, d); chk("ro_reg9", d, 32'h44556677);
    wr(4'd15, 4'hf, 32'h0);
    rd(4'd15, d); chk("ro_done", d, 32'h1);

    // START=1 in HOLD keeps the run held
    wr(4'd14, 4'h1, 32'h1);
    chk("hold_start", aes_start, 1'b1);
    rd(4'd15, d); chk("hold_done", d, 32'h1);

    // Clear START: back to IDLE, result retained
    wr(4'd14, 4'h1, 32'h0);
    chk("clr_start", aes_start, 1'b0);
    rd(4'd15, d); chk("clr_done", d, 32'h0);
    rd(4'd8, d);  chk("clr_dec8", d, 32'h00112233);
    rd(4'd14, d); chk("clr_startreg", d, 32'h0);

    // Chip select low reads zero
    @(negedge clk);
    cs = 1'b0; rd_s = 1'b1; addr = 4'd8;
    #1;
    chk("cs_low", rdata, 32'h0);
    rd_s = 1'b0;

    // Reset during RUN
    model_en = 1'b0;
    wr(4'd14, 4'h1, 32'h1);
    chk("run2_start", aes_start, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_run_start", aes_start, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), d);
      chk($sformatf("rst_run_reg%0d", i), d, 32'h0);
    end
    chk("rst_run_key", aes_key, 128'h0);

    // Abort in the same cycle AES_DONE rises
    wr(4'd14, 4'h1, 32'h1);
    chk("run3_start", aes_start, 1'b1);
    @(negedge clk);
    cs = 1'b1; wr_s = 1'b1; addr = 4'd14; be = 4'h1; wdata = 32'h0;
    force_done = 1'b1;
    @(posedge clk); #1;
    cs = 1'b0; wr_s = 1'b0; force_done = 1'b0;
    chk("abort_start", aes_start, 1'b0);
    rd(4'd15, d); chk("abort_done", d, 32'h0);
    rd(4'd8, d);  chk("abort_dec8", d, 32'h0);
    rd(4'd11, d); chk("abort_dec11", d, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit reached");
  end

endmodule
